// File: rtl/cnn_image_streamer_pkg.sv
// Shared types and default geometry for the CNN image streamer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cnn_image_streamer_pkg;

   localparam int DEF_RESOLUTION   = 8;
   localparam int DEF_ADDRWIDE     = 10;
   localparam int DEF_IMG_W        = 28;
   localparam int DEF_IMG_H        = 28;
   localparam int DEF_NUM_CLASSES  = 10;
   localparam int DEF_TIMEOUT      = 65535;

   // Pixel count of the default image geometry
   localparam int IMG_PIXELS = DEF_IMG_W * DEF_IMG_H;

   // Width of a class index; a single-class build still gets a 1-bit port
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int CLASS_IDX_W = idx_width(DEF_NUM_CLASSES);

   typedef enum logic [2:0] {
      ST_LOAD      = 3'd0,
      ST_STREAM    = 3'd1,
      ST_WAIT_PRED = 3'd2,
      ST_ARGMAX    = 3'd3,
      ST_RESULT    = 3'd4
   } streamer_state_t;

endpackage

// File: rtl/cnn_image_streamer_ram.sv
// Single-port synchronous pixel buffer; contents are never cleared.
// Latency: 1 cycle read; the read register only updates when i_re is high.
// Backpressure: none; holding i_re low keeps o_rdata stable during stalls.
module cnn_streamer_ram #(
   parameter int DEPTH  = 784,
   parameter int WIDTH  = 8,
   parameter int ADDR_W = 10
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_we,
   input  logic              i_re,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [WIDTH-1:0]  i_wdata,
   output logic [WIDTH-1:0]  o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rdata;

   // Storage write; no reset so an image survives a reset
   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
   end

   // Registered read port, cleared by reset so the pixel output starts at 0
   always_ff @(posedge i_clk) begin
      if (!i_rst_n)  r_rdata <= '0;
      else if (i_re) r_rdata <= r_mem[i_addr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/cnn_image_streamer.sv
// Loads an image from the host, replays it to the CNN, argmaxes the returned scores.
// Latency: first pixel 2 cycles after last load; result NUM_CLASSES+1 cycles after prediction.
// Backpressure: pixel stream holds on !pix_ready_i; result holds on !class_ready_i. Watchdog: CNN_STREAMER_WATCHDOG_EN.
module cnn_image_streamer
   import cnn_image_streamer_pkg::*;
#(
   parameter int FEATURE_MAP_RESOLUTION = DEF_RESOLUTION,
   parameter int FEATURE_MAP_ADDRWIDE   = DEF_ADDRWIDE,
   parameter int IMG_W                  = DEF_IMG_W,
   parameter int IMG_H                  = DEF_IMG_H,
   parameter int NUM_CLASSES            = DEF_NUM_CLASSES,
   parameter int TIMEOUT_CYCLES         = DEF_TIMEOUT
) (
   input  logic                                          clk_i,
   input  logic                                          rst_ni,
   input  logic                                          load_valid_i,
   input  logic [FEATURE_MAP_RESOLUTION-1:0]             load_data_i,
   output logic                                          load_ready_o,
   output logic                                          pix_valid_o,
   output logic [FEATURE_MAP_RESOLUTION-1:0]             pix_data_o,
   output logic [FEATURE_MAP_ADDRWIDE-1:0]               pix_addr_o,
   input  logic                                          pix_ready_i,
   input  logic                                          pred_valid_i,
   input  logic [NUM_CLASSES*FEATURE_MAP_RESOLUTION-1:0] pred_data_i,
   output logic                                          pred_ready_o,
   output logic                                          class_valid_o,
   output logic [idx_width(NUM_CLASSES)-1:0]             class_idx_o,
   output logic [FEATURE_MAP_RESOLUTION-1:0]             class_score_o,
   output logic                                          class_err_o,
   input  logic                                          class_ready_i
);

   localparam int W     = FEATURE_MAP_RESOLUTION;
   localparam int AW    = FEATURE_MAP_ADDRWIDE;
   localparam int NPIX  = IMG_W * IMG_H;
   localparam int IDX_W = idx_width(NUM_CLASSES);
   localparam logic [AW-1:0]    LAST_ADDR = AW'(NPIX - 1);
   localparam logic [IDX_W-1:0] LAST_CLS  = IDX_W'(NUM_CLASSES - 1);

   streamer_state_t r_state, w_state_nxt;

   logic [AW-1:0]            r_wr_ptr;
   logic [AW-1:0]            r_pix_addr;
   logic                     r_pix_vld;
   logic [NUM_CLASSES*W-1:0] r_scores;
   logic [IDX_W-1:0]         r_cls_cnt;
   logic [IDX_W-1:0]         r_best_idx;
   logic [W-1:0]             r_best_score;

   logic          w_load_hs, w_pix_hs, w_pix_last, w_pred_hs;
   logic          w_ram_re, w_ram_we, w_take, w_timeout, w_to_fire;
   logic [AW-1:0] w_ram_addr;
   logic [W-1:0]  w_cur_score;
   logic [W-1:0]  w_ram_rdata;

   assign w_load_hs  = load_valid_i && load_ready_o;
   assign w_pix_hs   = r_pix_vld && pix_ready_i;
   assign w_pix_last = (r_pix_addr == LAST_ADDR);
   assign w_pred_hs  = pred_valid_i && pred_ready_o;
   assign w_to_fire  = w_timeout && !pred_valid_i;

   // Argmax: index 0 always seeds the running best, later only strictly greater wins
   assign w_cur_score = r_scores[int'(r_cls_cnt) * W +: W];
   assign w_take      = (r_cls_cnt == '0) || ($signed(w_cur_score) > $signed(r_best_score));

   // Single port: LOAD writes at the write pointer, STREAM prefetches the next pixel
   assign w_ram_we   = w_load_hs;
   assign w_ram_addr = (r_state == ST_LOAD) ? r_wr_ptr :
                       (r_pix_vld ? r_pix_addr + AW'(1) : '0);

   cnn_streamer_ram #(
      .DEPTH  (NPIX),
      .WIDTH  (W),
      .ADDR_W (AW)
   ) u_ram (
      .i_clk   (clk_i),
      .i_rst_n (rst_ni),
      .i_we    (w_ram_we),
      .i_re    (w_ram_re),
      .i_addr  (w_ram_addr),
      .i_wdata (load_data_i),
      .o_rdata (w_ram_rdata)
   );

   // FSM state register
   always_ff @(posedge clk_i) begin
      if (!rst_ni) r_state <= ST_LOAD;
      else         r_state <= w_state_nxt;
   end

   // Next state, per-state ready/valid strobes and buffer read issue
   always_comb begin
      w_state_nxt   = r_state;
      load_ready_o  = 1'b0;
      pred_ready_o  = 1'b0;
      class_valid_o = 1'b0;
      w_ram_re      = 1'b0;
      case (r_state)
         ST_LOAD: begin
            load_ready_o = 1'b1;
            if (load_valid_i && (r_wr_ptr == LAST_ADDR)) w_state_nxt = ST_STREAM;
         end
         ST_STREAM: begin
            if (!r_pix_vld) begin
               w_ram_re = 1'b1;
            end else if (pix_ready_i) begin
               if (w_pix_last) w_state_nxt = ST_WAIT_PRED;
               else            w_ram_re    = 1'b1;
            end
         end
         ST_WAIT_PRED: begin
            pred_ready_o = 1'b1;
            if (pred_valid_i)   w_state_nxt = ST_ARGMAX;
            else if (w_timeout) w_state_nxt = ST_RESULT;
         end
         ST_ARGMAX: begin
            if (r_cls_cnt == LAST_CLS) w_state_nxt = ST_RESULT;
         end
         ST_RESULT: begin
            class_valid_o = 1'b1;
            if (class_ready_i) w_state_nxt = ST_LOAD;
         end
         default: w_state_nxt = ST_LOAD;
      endcase
   end

   // Datapath: write pointer, pixel stream registers, score capture and argmax
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_wr_ptr     <= '0;
         r_pix_vld    <= 1'b0;
         r_pix_addr   <= '0;
         r_scores     <= '0;
         r_cls_cnt    <= '0;
         r_best_idx   <= '0;
         r_best_score <= '0;
      end else begin
         if (w_load_hs) r_wr_ptr <= (r_wr_ptr == LAST_ADDR) ? '0 : r_wr_ptr + AW'(1);

         if (r_state == ST_STREAM) begin
            if (!r_pix_vld) begin
               r_pix_vld  <= 1'b1;
               r_pix_addr <= '0;
            end else if (w_pix_hs) begin
               if (w_pix_last) r_pix_vld  <= 1'b0;
               else            r_pix_addr <= r_pix_addr + AW'(1);
            end
         end

         if (w_pred_hs) begin
            r_scores  <= pred_data_i;
            r_cls_cnt <= '0;
         end

         if (r_state == ST_ARGMAX) begin
            if (w_take) begin
               r_best_idx   <= r_cls_cnt;
               r_best_score <= w_cur_score;
            end
            r_cls_cnt <= r_cls_cnt + IDX_W'(1);
         end

         if (w_to_fire) begin
            r_best_idx   <= '0;
            r_best_score <= '0;
         end
      end
   end

`ifdef CNN_STREAMER_WATCHDOG_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] r_wd_cnt;
   logic            r_err;

   // Watchdog counts WAIT_PRED cycles and is held at zero in every other state
   always_ff @(posedge clk_i) begin
      if (!rst_ni || (r_state != ST_WAIT_PRED)) r_wd_cnt <= '0;
      else                                      r_wd_cnt <= r_wd_cnt + WD_W'(1);
   end

   // Error flag marks a result produced by timeout instead of a prediction
   always_ff @(posedge clk_i) begin
      if (!rst_ni)        r_err <= 1'b0;
      else if (w_pred_hs) r_err <= 1'b0;
      else if (w_to_fire) r_err <= 1'b1;
   end

   assign w_timeout   = (r_state == ST_WAIT_PRED) && (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
   assign class_err_o = r_err;
`else
   assign w_timeout   = 1'b0;
   assign class_err_o = 1'b0;
`endif

   assign pix_valid_o   = r_pix_vld;
   assign pix_addr_o    = r_pix_addr;
   assign pix_data_o    = w_ram_rdata;
   assign class_idx_o   = r_best_idx;
   assign class_score_o = r_best_score;

endmodule

// File: tb/tb_cnn_image_streamer.sv
// Bench for cnn_image_streamer: image load/stream, argmax table, reset and watchdog sequences.
// Latency: checks first-pixel and result latencies against hand-derived cycle counts.
// Backpressure: drives toggling pix_ready_i and delayed class_ready_i.
module tb_cnn_image_streamer;

   localparam int NPIX = 784;
`ifdef CNN_STREAMER_WATCHDOG_EN
   localparam int TB_TIMEOUT = 100;
`else
   localparam int TB_TIMEOUT = 65535;
`endif

   typedef logic [9:0][7:0] scores_t;

   typedef struct {
      scores_t    sc;
      int         mult;
      int         off;
      int         mode;
      int         hold;
      logic [3:0] exp_idx;
      logic [7:0] exp_sc;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_ni;
   logic       load_valid_i;
   logic [7:0] load_data_i;
   logic       load_ready_o;
   logic       pix_valid_o;
   logic [7:0] pix_data_o;
   logic [9:0] pix_addr_o;
   logic       pix_ready_i;
   logic       pred_valid_i;
   scores_t    pred_data_i;
   logic       pred_ready_o;
   logic       class_valid_o;
   logic [3:0] class_idx_o;
   logic [7:0] class_score_o;
   logic       class_err_o;
   logic       class_ready_i;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   cnn_image_streamer #(
      .TIMEOUT_CYCLES (TB_TIMEOUT)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_ni),
      .load_valid_i  (load_valid_i),
      .load_data_i   (load_data_i),
      .load_ready_o  (load_ready_o),
      .pix_valid_o   (pix_valid_o),
      .pix_data_o    (pix_data_o),
      .pix_addr_o    (pix_addr_o),
      .pix_ready_i   (pix_ready_i),
      .pred_valid_i  (pred_valid_i),
      .pred_data_i   (pred_data_i),
      .pred_ready_o  (pred_ready_o),
      .class_valid_o (class_valid_o),
      .class_idx_o   (class_idx_o),
      .class_score_o (class_score_o),
      .class_err_o   (class_err_o),
      .class_ready_i (class_ready_i)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   function automatic scores_t mk(input int a0, input int a1, input int a2, input int a3,
                                  input int a4, input int a5, input int a6, input int a7,
                                  input int a8, input int a9);
      scores_t s;
      s[0] = 8'(a0); s[1] = 8'(a1); s[2] = 8'(a2); s[3] = 8'(a3); s[4] = 8'(a4);
      s[5] = 8'(a5); s[6] = 8'(a6); s[7] = 8'(a7); s[8] = 8'(a8); s[9] = 8'(a9);
      return s;
   endfunction

   // Loads a full image of (addr*mult+off) mod 256; returns at the negedge one cycle after the last handshake
   task automatic load_image(input int mult, input int off);
      int not_rdy = 0;
      for (int a = 0; a < NPIX; a++) begin
         @(negedge clk);
         load_valid_i = 1'b1;
         load_data_i  = 8'(a * mult + off);
         if (!load_ready_o) not_rdy++;
      end
      @(negedge clk);
      load_valid_i = 1'b0;
      chk("load_ready_during_load", not_rdy, 0);
      chk("load_ready_after_last", load_ready_o, 0);
      chk("pix_valid_one_after_load", pix_valid_o, 0);
   endtask

   // Receives the stream; mode 0 = always ready, mode 1 = ready pattern 1,0,0; stop_at>=0 pulses reset at that pixel
   task automatic stream_image(input int mult, input int off, input int mode, input int stop_at);
      int got = 0, cyc = 0, bad = 0, unstable = 0, bubbles = 0;
      logic stalled = 1'b0;
      logic rdy;
      logic [9:0] pa = '0;
      logic [7:0] pd = '0;
      @(negedge clk);
      chk("first_pix_valid_two_after_load", pix_valid_o, 1);
      while (got < NPIX && cyc < 20000) begin
         if (stalled && (!pix_valid_o || pix_addr_o != pa || pix_data_o != pd)) unstable++;
         if (pix_valid_o) begin
            if (pix_addr_o != 10'(got) || pix_data_o != 8'(got * mult + off)) bad++;
         end else begin
            bubbles++;
         end
         if (stop_at >= 0 && got == stop_at && pix_valid_o) begin
            rst_ni      = 1'b0;
            pix_ready_i = 1'b1;
            break;
         end
         rdy = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
         pix_ready_i = rdy;
         stalled = pix_valid_o && !rdy;
         pa = pix_addr_o;
         pd = pix_data_o;
         if (pix_valid_o && rdy) got++;
         cyc++;
         @(negedge clk);
      end
      chk("stream_data_addr_errors", bad, 0);
      chk("stream_stall_unstable", unstable, 0);
      chk("stream_bubbles", bubbles, 0);
      if (stop_at < 0) begin
         pix_ready_i = 1'b0;
         chk("stream_pixel_count", got, NPIX);
         chk("pix_valid_after_last", pix_valid_o, 0);
         chk("pred_ready_in_wait", pred_ready_o, 1);
      end
   endtask

   // Sends a prediction from WAIT_PRED and checks the argmax result, its latency and its hold under stall
   task automatic predict(input scores_t sc, input logic [3:0] exp_idx, input logic [7:0] exp_sc,
                          input int hold);
      int lat = 1, unstable = 0;
      pred_valid_i = 1'b1;
      pred_data_i  = sc;
      @(negedge clk);
      pred_valid_i = 1'b0;
      pred_data_i  = '0;
      while (!class_valid_o && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      chk("result_latency", lat, 11);
      chk("class_idx", class_idx_o, exp_idx);
      chk("class_score", class_score_o, exp_sc);
      chk("class_err_clear", class_err_o, 0);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         if (!class_valid_o || class_idx_o != exp_idx || class_score_o != exp_sc) unstable++;
      end
      chk("result_hold_unstable", unstable, 0);
      class_ready_i = 1'b1;
      @(negedge clk);
      class_ready_i = 1'b0;
      chk("load_ready_after_consume", load_ready_o, 1);
      chk("class_valid_after_consume", class_valid_o, 0);
   endtask

   initial begin
      #900000;
      $display("FAIL global_timeout: simulation exceeded its time limit");
      $fatal(1);
   end

   initial begin
      vec_t tbl[6];
      tbl[0] = '{sc: mk(3, -5, 10, 0, 7, 10, 2, -128, 9, 1), mult: 1, off: 0, mode: 0, hold: 0,
                 exp_idx: 4'd2, exp_sc: 8'd10};
      tbl[1] = '{sc: mk(-3, -3, -3, -3, -3, -3, -3, -1, -3, -3), mult: 1, off: 0, mode: 1, hold: 5,
                 exp_idx: 4'd7, exp_sc: 8'hFF};
      tbl[2] = '{sc: mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), mult: 5, off: 3, mode: 0, hold: 1,
                 exp_idx: 4'd0, exp_sc: 8'h00};
      tbl[3] = '{sc: mk(-128, -128, -128, -128, -128, -128, -128, -128, -128, 127), mult: 7, off: 200,
                 mode: 1, hold: 0, exp_idx: 4'd9, exp_sc: 8'h7F};
      tbl[4] = '{sc: mk(-1, -2, -3, -4, -5, -6, -7, -8, -9, -10), mult: 255, off: 1, mode: 0, hold: 2,
                 exp_idx: 4'd0, exp_sc: 8'hFF};
      tbl[5] = '{sc: mk(100, -128, -128, 127, -128, -128, -128, -128, 127, -128), mult: 13, off: 77,
                 mode: 0, hold: 3, exp_idx: 4'd3, exp_sc: 8'h7F};

      rst_ni        = 1'b0;
      load_valid_i  = 1'b0;
      load_data_i   = '0;
      pix_ready_i   = 1'b0;
      pred_valid_i  = 1'b0;
      pred_data_i   = '0;
      class_ready_i = 1'b0;
      repeat (2) @(negedge clk);

      chk("rst_load_ready", load_ready_o, 1);
      chk("rst_pix_valid", pix_valid_o, 0);
      chk("rst_pix_addr", pix_addr_o, 0);
      chk("rst_pix_data", pix_data_o, 0);
      chk("rst_pred_ready", pred_ready_o, 0);
      chk("rst_class_valid", class_valid_o, 0);
      chk("rst_class_idx", class_idx_o, 0);
      chk("rst_class_score", class_score_o, 0);
      chk("rst_class_err", class_err_o, 0);
      rst_ni = 1'b1;

      // A prediction offered outside WAIT_PRED must be ignored
      @(negedge clk);
      pred_valid_i = 1'b1;
      pred_data_i  = mk(1, 2, 3, 4, 5, 6, 7, 8, 9, 10);
      chk("pred_ready_in_load", pred_ready_o, 0);
      @(negedge clk);
      chk("still_load_after_stray_pred", load_ready_o, 1);
      chk("no_result_after_stray_pred", class_valid_o, 0);
      pred_valid_i = 1'b0;
      pred_data_i  = '0;

      // Reset pulse while pixel 400 is on the bus
      load_image(1, 0);
      stream_image(1, 0, 0, 400);
      @(negedge clk);
      rst_ni = 1'b1;
      pix_ready_i = 1'b0;
      chk("midrst_load_ready", load_ready_o, 1);
      chk("midrst_pix_valid", pix_valid_o, 0);
      chk("midrst_pix_addr", pix_addr_o, 0);
      chk("midrst_pix_data", pix_data_o, 0);
      chk("midrst_pred_ready", pred_ready_o, 0);

      for (int v = 0; v < 6; v++) begin
         load_image(tbl[v].mult, tbl[v].off);
         stream_image(tbl[v].mult, tbl[v].off, tbl[v].mode, -1);
         predict(tbl[v].sc, tbl[v].exp_idx, tbl[v].exp_sc, tbl[v].hold);
      end

`ifdef CNN_STREAMER_WATCHDOG_EN
      begin
         int lat = 1;
         load_image(3, 7);
         stream_image(3, 7, 0, -1);
         while (!class_valid_o && lat < 400) begin
            @(negedge clk);
            lat++;
         end
         chk("watchdog_latency", lat, TB_TIMEOUT + 1);
         chk("watchdog_err", class_err_o, 1);
         chk("watchdog_idx", class_idx_o, 0);
         chk("watchdog_score", class_score_o, 0);
         pred_valid_i = 1'b1;
         pred_data_i  = mk(0, 0, 50, 0, 0, 0, 0, 0, 0, 0);
         chk("late_pred_not_acked", pred_ready_o, 0);
         class_ready_i = 1'b1;
         @(negedge clk);
         class_ready_i = 1'b0;
         chk("watchdog_consumed_load_ready", load_ready_o, 1);
         chk("late_pred_not_acked_in_load", pred_ready_o, 0);
         pred_valid_i = 1'b0;
         pred_data_i  = '0;
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
